// File: rtl/fixed_divider_pkg.sv
// Shared types and constants for the divider scheduler slice.
// Widths follow the Q16.16 / 16-bit divisor operand format.
package fixed_divider_pkg;

  localparam int A_W = 32;
  localparam int B_W = 16;
  localparam int Q_W = 32;

  localparam logic [Q_W-1:0] DZ_QUOT_DEF = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic           id;
  } div_op_t;

  function automatic logic is_dz(input logic [B_W-1:0] b);
    return b == '0;
  endfunction

endpackage

// File: rtl/fixed_divider_scheduler_arb.sv
// Two-way round-robin grant; the last winner loses a tie.
// last_grant resets to 1 so requester 0 wins the first tie.
module rr_arbiter2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant,
  output logic       grant_id
);

  logic last_grant;

  always_comb begin
    grant_id = 1'b0;
    unique case (valid)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_grant;
      default: grant_id = 1'b0;
    endcase
  end

  always_comb begin
    grant = 2'b00;
    if (valid != 2'b00) begin
      grant = grant_id ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant_id;
    end
  end

endmodule

// File: rtl/fixed_divider_scheduler.sv
// Shares one fixed-latency divider between two requesters.
// Divide-by-zero is answered directly and never launches the divider.
module fixed_divider_scheduler
  import fixed_divider_pkg::*;
#(
  parameter int             DIV_LATENCY = 33,
  parameter logic [Q_W-1:0] DZ_QUOT     = DZ_QUOT_DEF
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [A_W-1:0] req0_a,
  input  logic [B_W-1:0] req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [A_W-1:0] req1_a,
  input  logic [B_W-1:0] req1_b,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [Q_W-1:0] rsp_quot,
  output logic           rsp_dz,
  output logic [A_W-1:0] div_a,
  output logic [B_W-1:0] div_b,
  output logic           div_init,
  input  logic [Q_W-1:0] div_prod,
  output logic           busy
);

  localparam int CW = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;

  state_t        state;
  logic [CW-1:0] cnt;
  div_op_t       op;
  div_op_t       sel;
  logic [1:0]    grant;
  logic          grant_id;
  logic          accept;
  logic          idle;

  assign idle = (state == IDLE);

  rr_arbiter2 u_arb (
    .clock    (clock),
    .reset    (reset),
    .valid    ({req1_valid, req0_valid}),
    .accept   (accept),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign req0_ready = idle && grant[0];
  assign req1_ready = idle && grant[1];
  assign accept     = (req0_valid && req0_ready)
                   || (req1_valid && req1_ready);

  always_comb begin
    sel.id = grant_id;
    sel.a  = grant_id ? req1_a : req0_a;
    sel.b  = grant_id ? req1_b : req0_b;
  end

  assign div_a = op.a;
  assign div_b = op.b;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      op        <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_quot  <= '0;
      rsp_dz    <= 1'b0;
      div_init  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            op     <= sel;
            rsp_id <= sel.id;
            busy   <= 1'b1;
            if (is_dz(sel.b)) begin
              state     <= RESP;
              rsp_quot  <= DZ_QUOT;
              rsp_dz    <= 1'b1;
              rsp_valid <= 1'b1;
            end else begin
              state    <= LAUNCH;
              rsp_dz   <= 1'b0;
              div_init <= 1'b1;
            end
          end
        end
        LAUNCH: begin
          state    <= WAIT;
          div_init <= 1'b0;
          cnt      <= CW'(DIV_LATENCY - 1);
        end
        WAIT: begin
          // div_prod is valid in the cycle the count hits zero
          if (cnt == '0) begin
            rsp_quot  <= div_prod;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_divider_scheduler.sv
// Randomized bench for the divider scheduler against a timing/arith model.
// A behavioural fixed-latency divider drives div_prod only when due.
module tb_fixed_divider_scheduler;

  localparam int          L   = 8;
  localparam logic [31:0] DZQ = 32'hFFFF_FFFF;

  logic        clock = 1'b0;
  logic        reset;
  logic        v [2];
  logic [31:0] a [2];
  logic [15:0] b [2];
  logic        req0_ready, req1_ready;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_dz;
  logic [31:0] rsp_quot, div_a, div_prod;
  logic [15:0] div_b;
  logic        div_init, busy;

  always #5 clock = ~clock;

  fixed_divider_scheduler #(
    .DIV_LATENCY (L),
    .DZ_QUOT     (DZQ)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req0_valid (v[0]),
    .req0_ready (req0_ready),
    .req0_a     (a[0]),
    .req0_b     (b[0]),
    .req1_valid (v[1]),
    .req1_ready (req1_ready),
    .req1_a     (a[1]),
    .req1_b     (b[1]),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_quot   (rsp_quot),
    .rsp_dz     (rsp_dz),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_init   (div_init),
    .div_prod   (div_prod),
    .busy       (busy)
  );

  // divider model: result valid L cycles after init falls
  int          dc = 0;
  logic [31:0] qa;
  logic [15:0] qb;
  always @(posedge clock) begin
    if (reset) dc = 0;
    else if (div_init) dc = L;
    else if (dc > 0) dc = dc - 1;
    qa = div_a;
    qb = div_b;
    #1;
    div_prod = (dc == 1 && qb != 0) ? qa / {16'h0, qb} : $urandom;
  end

  int          total = 0;
  int          bad   = 0;
  bit          act   = 0;
  bit          lg    = 1;
  bit          lid   = 0;
  int          n     = 0;
  logic [31:0] la    = '0;
  logic [15:0] lb    = '0;
  bit          ids [$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic newop(input int i);
    v[i] = 1'b1;
    a[i] = $urandom;
    b[i] = ($urandom_range(0, 5) == 0) ? 16'h0
         : ($urandom_range(0, 1) == 0) ? 16'($urandom_range(1, 9))
         : 16'($urandom);
  endtask

  task automatic cycle(input bit rst, input bit rr, input bit refill);
    bit g, gv, acc, take, idle, ev;
    acc  = 0;
    take = 0;
    g    = 0;
    reset     = rst;
    rsp_ready = rr;
    @(negedge clock);
    if (!rst) begin
      idle = !act;
      gv   = v[0] | v[1];
      g    = (v[0] && v[1]) ? !lg : v[1];
      chk("req0_ready", 32'(req0_ready), 32'(idle && gv && !g));
      chk("req1_ready", 32'(req1_ready), 32'(idle && gv && g));
      chk("busy", 32'(busy), 32'(act));
      chk("div_init", 32'(div_init), 32'(act && lb != 0 && n == 1));
      ev = act && (n >= ((lb == 0) ? 1 : L + 2));
      chk("rsp_valid", 32'(rsp_valid), 32'(ev));
      if (ev) begin
        chk("rsp_id", 32'(rsp_id), 32'(lid));
        chk("rsp_quot", rsp_quot,
            (lb == 0) ? DZQ : la / {16'h0, lb});
        chk("rsp_dz", 32'(rsp_dz), 32'(lb == 0));
      end
      chk("div_a", div_a, la);
      chk("div_b", 32'(div_b), 32'(lb));
      acc  = idle && gv;
      take = ev && rr;
    end
    @(posedge clock);
    #1;
    if (rst) begin
      act = 0; lg = 1; lid = 0; la = '0; lb = '0;
    end else if (take) begin
      act = 0;
      ids.push_back(lid);
    end else if (acc) begin
      act = 1; n = 1; lg = g; lid = g;
      la = a[g]; lb = b[g];
      if (refill) newop(int'(g));
      else v[g] = 1'b0;
    end else if (act) begin
      n++;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (act || v[0] || v[1]); i++)
      cycle(0, 1, 0);
    chk("drained", 32'(act), 32'(0));
  endtask

  initial begin
    v[0] = 0; v[1] = 0;
    a[0] = '0; a[1] = '0; b[0] = '0; b[1] = '0;
    reset = 1; rsp_ready = 0;
    @(posedge clock); #1;
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    chk("rst_quot", rsp_quot, 32'h0);
    chk("rst_id", 32'(rsp_id), 32'h0);
    chk("rst_dz", 32'(rsp_dz), 32'h0);
    cycle(0, 0, 0);

    // single request, then scramble operands after accept
    v[0] = 1; a[0] = 32'h0003_0000; b[0] = 16'h0002;
    cycle(0, 1, 0);
    a[0] = 32'h1234_5678; b[0] = 16'h0007;
    for (int i = 0; i < L + 4; i++) cycle(0, 1, 0);
    chk("single_id", 32'(ids.size()), 32'd1);

    // tie after reset, rsp_ready held high
    cycle(1, 0, 0);
    ids.delete();
    newop(0); newop(1);
    b[0] = 16'd3; b[1] = 16'd5;
    for (int i = 0; i < 4 * (L + 3) + 4; i++) cycle(0, 1, 1);
    chk("tie_count", 32'(ids.size() >= 4), 32'd1);
    if (ids.size() >= 4) begin
      for (int i = 0; i < 4; i++)
        chk("tie_seq", 32'(ids[i]), 32'(i % 2));
    end
    v[0] = 0; v[1] = 0;
    drain();

    // divide by zero on requester 1
    v[1] = 1; a[1] = $urandom; b[1] = 16'h0;
    for (int i = 0; i < 4; i++) cycle(0, 1, 0);

    // backpressure with req0 holding a second request
    v[0] = 1; a[0] = 32'h0010_0000; b[0] = 16'h0004;
    cycle(0, 0, 1);
    for (int i = 0; i < L + 11; i++) cycle(0, 0, 1);
    cycle(0, 1, 1);
    cycle(0, 0, 0);
    drain();

    // reset while waiting on the divider
    v[0] = 1; a[0] = 32'h0100_0000; b[0] = 16'h0003;
    cycle(0, 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0);
    cycle(1, 1, 0);
    v[0] = 1; v[1] = 1;
    for (int i = 0; i < 3; i++) cycle(0, 1, 0);
    drain();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++)
        if (!v[i] && $urandom_range(0, 3) == 0) newop(i);
      cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), 0);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fixed_divider_scheduler.md
# fixed_divider_scheduler

Shares one `fixed_divider` instance between two requesters, for example two operand-entry front ends. Each request is a Q16.16 dividend and a 16-bit divisor. The block arbitrates round-robin and launches the divider with a one-cycle `init` pulse. It waits out the divider's fixed latency, captures the 32-bit quotient and returns it tagged with the requester ID, using valid/ready handshakes on both sides. Divide-by-zero is detected up front and never reaches the divider.

## Interface
Parameters:
- `DIV_LATENCY`, default 33: cycles from the `div_init` falling edge until `div_prod` is valid; must be ≥1.
- `DZ_QUOT`, default 32'hFFFF_FFFF: quotient returned on divide-by-zero.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req0_valid` in 1 / `req0_ready` out 1: requester 0 handshake.
- `req0_a` in 32 / `req0_b` in 16: requester 0 dividend and divisor.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`: same as requester 0, for requester 1.
- `rsp_valid` out 1 / `rsp_ready` in 1: response handshake.
- `rsp_id` out 1: index of the requester that issued the request.
- `rsp_quot` out 32: quotient.
- `rsp_dz` out 1: divide-by-zero flag.
- `div_a` out 32 / `div_b` out 16 / `div_init` out 1: drive the divider's `numA`, `numB` and `init`.
- `div_prod` in 32: divider result.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- States:
  - IDLE: accept a request.
  - LAUNCH: `div_init` = 1 for exactly one cycle.
  - WAIT: count `DIV_LATENCY` cycles.
  - RESP: hold the response until it is taken.
- Arbitration:
  - `reqN_ready` = (state == IDLE) && grant == N. Ready is combinational from state, `last_grant` and both valids.
  - Only one request is ever accepted per cycle.
  - If only one requester is valid, it is granted.
  - If both are valid, the one not equal to `last_grant` is granted.
  - `last_grant` updates only on an accept.
- Accept (valid && ready at an edge):
  - Latch a, b and the ID into internal registers.
  - If b == 0, go to RESP with `rsp_quot` = `DZ_QUOT`, `rsp_dz` = 1; the divider is not launched.
  - Otherwise go to LAUNCH with `rsp_dz` = 0.
- LAUNCH → WAIT. Load the counter with `DIV_LATENCY`-1.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 0, capture `div_prod` into `rsp_quot` and go to RESP.
- RESP:
  - `rsp_valid` = 1.
  - When `rsp_ready` = 1, go to IDLE.
  - `rsp_id`, `rsp_quot` and `rsp_dz` are stable while `rsp_valid` is high and unacknowledged.
- `div_a` and `div_b` are driven from the latched operands. They are stable from LAUNCH through the capture cycle and hold their last values in IDLE.
- Arithmetic: no rounding or saturation inside this block. The quotient is passed through unchanged.

## Timing
- Reset values: state IDLE, `last_grant` = 1 (requester 0 wins the first tie). All outputs are 0: `req*_ready`, `rsp_valid`, `rsp_id`, `rsp_quot`, `rsp_dz`, `div_a`, `div_b`, `div_init`, `busy`.
- Accept at edge T:
  - `div_init` high in cycle T+1.
  - Capture at edge T+1+`DIV_LATENCY`.
  - `rsp_valid` high from cycle T+2+`DIV_LATENCY`.
- Divide-by-zero accepted at edge T: `rsp_valid` high from cycle T+1.
- Response taken at edge R: IDLE from cycle R+1, and a new accept is possible at edge R+1. The pipeline does not accept in the same cycle as a response is taken.
- A new request arriving while busy sees `ready` = 0 and must hold valid. No request is dropped.
- Reset mid-operation (any state) takes effect at the next edge:
  - In-flight work is discarded and no response is produced.
  - `div_init` goes to 0.
  - `last_grant` returns to 1.
- `reset` and `rsp_ready` in the same cycle: reset wins.

## Structure
- Package `fixed_divider_pkg` holds:
  - the state enum (IDLE, LAUNCH, WAIT, RESP);
  - width constants A_W = 32, B_W = 16, Q_W = 32;
  - the default `DZ_QUOT`.
- One natural sub-module, `rr_arbiter2`: a two-way round-robin grant with a `last_grant` register. Inputs are two valids and an accept strobe; outputs are the grant one-hot and the grant ID.
- The divider is instantiated by the parent. This block only drives its ports.

## Test plan
- Single request: req0 a=32'h0003_0000, b=16'h0002, `div_prod` model returns 32'h0001_8000. Expected: `rsp_valid` exactly `DIV_LATENCY`+2 cycles after accept, `rsp_id`=0, `rsp_quot`=32'h0001_8000, `rsp_dz`=0, `div_init` high exactly one cycle.
- Tie after reset: both requesters valid with distinct operands, `rsp_ready` tied to 1. Expected: req0 served first, then req1, then req0, alternating strictly; `rsp_id` sequence 0,1,0,1.
- Divide-by-zero: req1 b=0. Expected: `rsp_valid` one cycle after accept, `rsp_quot`=32'hFFFF_FFFF, `rsp_dz`=1, `rsp_id`=1, `div_init` never asserted.
- Backpressure: hold `rsp_ready`=0 for 10 cycles in RESP while req0 is valid. Expected: outputs stable, `req0_ready`=0 throughout; after the response is taken, req0 is accepted one cycle later.
- Reset in WAIT: assert `reset` 5 cycles after LAUNCH. Expected: IDLE next cycle, all outputs 0, no `rsp_valid` pulse; a subsequent tie is granted to req0.
- Operand stability: change `req0_a` and `req0_b` after accept. Expected: `div_a` and `div_b` stay unchanged until capture.
